stuff_data_mapper: RTL and testbench

- Sits directly downstream of the stuff-or-data scheduler and consumes its per-slot data/stuff decision stream (sof, valid, ds).
- Buffers client words in an internal FIFO and builds the outgoing frame: one FIFO word per ds=1 slot, one fixed stuff word per ds=0 slot.
- Counts the data slots in each frame and flags underflow and framing errors.

---
 rtl/stuff_mapper_pkg.sv | 17 +
 rtl/stuff_data_mapper_if.sv | 25 ++
 rtl/stuff_data_mapper_sync_fifo.sv | 72 +++++++
 rtl/stuff_data_mapper.sv | 159 +++++++++++++++
 tb/tb_stuff_data_mapper.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/stuff_mapper_pkg.sv
// Shared types and constants for the stuff/data mapper.
package stuff_mapper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } map_state_e;

    localparam logic [7:0] DEFAULT_STUFF_WORD = 8'h00;

    // Level counter needs one extra bit so that "full" (== depth) is representable.
    function automatic int fifo_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stuff_data_mapper_if.sv
// Client stream, scheduler slot stream and line output of the stuff/data mapper.
interface stuff_data_mapper_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sched_sof;
    logic              sched_valid;
    logic              sched_ds;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_sof;
    logic              out_is_stuff;

    modport master (
        output in_data, in_valid, sched_sof, sched_valid, sched_ds,
        input  in_ready, out_data, out_valid, out_sof, out_is_stuff
    );

    modport slave (
        input  in_data, in_valid, sched_sof, sched_valid, sched_ds,
        output in_ready, out_data, out_valid, out_sof, out_is_stuff
    );
endinterface

// File: rtl/stuff_data_mapper_sync_fifo.sv
// Client word FIFO: combinational head read, registered full/empty/level.
module sync_fifo
    import stuff_mapper_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  logic [DATA_W-1:0]                   push_data,
    input  logic                                pop,
    output logic [DATA_W-1:0]                   head_data,
    output logic                                full,
    output logic                                empty,
    output logic [fifo_level_w(FIFO_DEPTH)-1:0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = fifo_level_w(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    // Next pointers/level; full/empty come from the pointer MSB comparison.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_q[AW-1:0]];
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;
endmodule

// File: rtl/stuff_data_mapper.sv
// Stuff/data mapper: turns scheduler slot decisions into a line frame,
// popping client words for data slots and emitting STUFF_WORD otherwise.
// Optional macro STUFF_DATA_MAPPER_ERR_CNT_EN adds a saturating err_cnt output.
module stuff_data_mapper
    import stuff_mapper_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] STUFF_WORD = DATA_W'(DEFAULT_STUFF_WORD),
    parameter int                CNT_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    stuff_data_mapper_if.slave                  bus,
    output logic [CNT_W-1:0]                    last_frame_cm,
    output logic                                err_underflow,
    output logic                                err_no_sof,
`ifdef STUFF_DATA_MAPPER_ERR_CNT_EN
    output logic [15:0]                         err_cnt,
`endif
    output logic [fifo_level_w(FIFO_DEPTH)-1:0] fifo_level
);
    map_state_e        state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_stuff_q, out_stuff_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  last_cm_q, last_cm_d;
    logic              err_uf_q, err_uf_d;
    logic              err_ns_q, err_ns_d;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full, fifo_empty, fifo_pop;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Frame FSM, slot mux, data-slot counter and error detection.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_stuff_d = out_stuff_q;
        cnt_d       = cnt_q;
        last_cm_d   = last_cm_q;
        err_uf_d    = 1'b0;
        err_ns_d    = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sched_sof) begin
                    state_d = ARMED;
                end else if (bus.sched_valid) begin
                    err_ns_d = 1'b1;
                end
            end
            ARMED, RUN: begin
                if (bus.sched_sof) begin
                    // Closing a running frame publishes its count; re-arming is idempotent.
                    if (state_q == RUN) begin
                        last_cm_d = cnt_q;
                        cnt_d     = '0;
                    end
                    state_d = ARMED;
                end else if (bus.sched_valid) begin
                    out_valid_d = 1'b1;
                    out_sof_d   = (state_q == ARMED);
                    state_d     = RUN;
                    if (bus.sched_ds && !fifo_empty) begin
                        fifo_pop    = 1'b1;
                        out_data_d  = fifo_head;
                        out_stuff_d = 1'b0;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // Scheduled stuff, or a data slot that found nothing buffered.
                        out_data_d  = STUFF_WORD;
                        out_stuff_d = 1'b1;
                        err_uf_d    = bus.sched_ds;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered state and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= STUFF_WORD;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_stuff_q <= 1'b0;
            cnt_q       <= '0;
            last_cm_q   <= '0;
            err_uf_q    <= 1'b0;
            err_ns_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_stuff_q <= out_stuff_d;
            cnt_q       <= cnt_d;
            last_cm_q   <= last_cm_d;
            err_uf_q    <= err_uf_d;
            err_ns_q    <= err_ns_d;
        end
    end

`ifdef STUFF_DATA_MAPPER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating error-event count; simultaneous errors count once.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((err_uf_d || err_ns_d) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign bus.in_ready     = !fifo_full;
    assign bus.out_data     = out_data_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sof      = out_sof_q;
    assign bus.out_is_stuff = out_stuff_q;
    assign last_frame_cm    = last_cm_q;
    assign err_underflow    = err_uf_q;
    assign err_no_sof       = err_ns_q;
endmodule

// File: tb/tb_stuff_data_mapper.sv
// Scoreboard bench for stuff_data_mapper: slots push expected line words,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_stuff_data_mapper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] last_frame_cm;
    logic       err_underflow;
    logic       err_no_sof;
    logic [4:0] fifo_level;
`ifdef STUFF_DATA_MAPPER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    always #5 clk = ~clk;

    stuff_data_mapper_if #(.DATA_W(8)) bus ();

    stuff_data_mapper dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .last_frame_cm (last_frame_cm),
        .err_underflow (err_underflow),
        .err_no_sof    (err_no_sof),
`ifdef STUFF_DATA_MAPPER_ERR_CNT_EN
        .err_cnt       (err_cnt),
`endif
        .fifo_level    (fifo_level)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       stuff;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: every line word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: out_data 0x%0h with no slot outstanding", bus.out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("line word: data=0x%02h sof=%0b stuff=%0b (want 0x%02h %0b %0b)",
                         bus.out_data, bus.out_sof, bus.out_is_stuff, e.data, e.sof, e.stuff);
                check("slot", {21'd0, bus.out_data, 1'b0, bus.out_sof, bus.out_is_stuff},
                      {21'd0, e.data, 1'b0, e.sof, e.stuff});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic sof_pulse();
        bus.sched_sof = 1'b1;
        tick();
        bus.sched_sof = 1'b0;
    endtask

    task automatic slot(input logic ds, input logic [7:0] d, input logic s, input logic st);
        exp_t e;
        e.data  = d;
        e.sof   = s;
        e.stuff = st;
        exp_q.push_back(e);
        bus.sched_valid = 1'b1;
        bus.sched_ds    = ds;
        tick();
        bus.sched_valid = 1'b0;
    endtask

    // Slot with no frame start: no line word (monitor flags any), err_no_sof pulses.
    task automatic orphan_slot();
        bus.sched_valid = 1'b1;
        bus.sched_ds    = 1'b1;
        tick();
        bus.sched_valid = 1'b0;
        check("err_no_sof_pulse", err_no_sof, 1);
`ifdef STUFF_DATA_MAPPER_ERR_CNT_EN
        check("err_cnt", err_cnt, 1);
`endif
        tick();
        check("err_no_sof_clear", err_no_sof, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.sched_sof   = 1'b0;
        bus.sched_valid = 1'b0;
        bus.sched_ds    = 1'b0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_last_cm", last_frame_cm, 0);
        tick();
        rst_n = 1'b1;
        tick();

        orphan_slot();

        // Basic frame.
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        check("level_after_preload", fifo_level, 4);
        sof_pulse();
        slot(1'b1, 8'h11, 1'b1, 1'b0);
        slot(1'b0, 8'h00, 1'b0, 1'b1);
        slot(1'b1, 8'h22, 1'b0, 1'b0);
        slot(1'b1, 8'h33, 1'b0, 1'b0);
        slot(1'b0, 8'h00, 1'b0, 1'b1);
        sof_pulse();
        check("last_cm_frame1", last_frame_cm, 3);
        check("level_after_frame1", fifo_level, 1);

        // Drain the last word, then underflow with a simultaneous push.
        slot(1'b1, 8'h44, 1'b1, 1'b0);
        sof_pulse();
        check("last_cm_frame2", last_frame_cm, 1);
        check("level_empty", fifo_level, 0);
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        slot(1'b1, 8'h00, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        check("err_underflow_pulse", err_underflow, 1);
        check("level_after_uf_push", fifo_level, 1);
        slot(1'b1, 8'hA5, 1'b0, 1'b0);
        check("err_underflow_clear", err_underflow, 0);

        // Fill to full, pop one, refill.
        for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
        check("full_in_ready", bus.in_ready, 0);
        check("full_level", fifo_level, 16);
        slot(1'b1, 8'h80, 1'b0, 1'b0);
        check("in_ready_after_pop", bus.in_ready, 1);
        check("level_after_pop", fifo_level, 15);
        push_word(8'h90);
        check("refill_level", fifo_level, 16);
        check("refill_in_ready", bus.in_ready, 0);

        // Frame with count 2 (underflow slot not counted), then a partial frame.
        sof_pulse();
        check("last_cm_frame3", last_frame_cm, 2);
        for (int i = 0; i < 11; i++) slot(1'b1, 8'h81 + 8'(i), (i == 0), 1'b0);
        check("level_mid_frame", fifo_level, 5);

        // Asynchronous reset mid-frame, away from any clock edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 8'h00);
        check("arst_out_sof", bus.out_sof, 0);
        check("arst_out_stuff", bus.out_is_stuff, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_level", fifo_level, 0);
        check("arst_last_cm", last_frame_cm, 0);
        check("arst_errs", {err_underflow, err_no_sof}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_level", fifo_level, 0);
        orphan_slot();

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
